// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver slice.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } uart_rx_state_t;

   localparam int UartOversample = 16;
   localparam int UartSampleMid  = 8;

   // Two-of-three vote used to reject single-sample noise on the line.
   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversampling prescaler: one-cycle tick every TicksPerSample enabled clocks.
module uart_rx_tick_gen #(
   parameter int TicksPerSample = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int CntW = $clog2(TicksPerSample + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(TicksPerSample - 1);

   logic [CntW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= (cnt == CntLast) ? '0 : cnt + CntW'(1);
      end
   end

   assign tick = enable && !clear && (cnt == CntLast);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, majority-voted bits, valid/ready output.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int CLK_FREQ_HZ = 300000000,
   parameter int BAUD_RATE   = 115200
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_uart,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  o_frame_error,
   output logic                  o_overrun
);

   localparam int TicksPerSample = CLK_FREQ_HZ / (BAUD_RATE * UartOversample);
   localparam int BitCntW        = $clog2(DATA_WIDTH + 1);
   localparam logic [3:0] SampleFirst = 4'(UartSampleMid - 1);
   localparam logic [3:0] SampleMid   = 4'(UartSampleMid);
   localparam logic [3:0] SampleVote  = 4'(UartSampleMid + 1);
   localparam logic [3:0] SampleLast  = 4'(UartOversample - 1);
   localparam logic [BitCntW-1:0] BitLast = BitCntW'(DATA_WIDTH - 1);

   if (TicksPerSample < 1) begin : g_bad_baud
      $error("uart_rx: clock too slow for 16x oversampling at this baud rate");
   end

   uart_rx_state_t state, state_next;

   logic                  rx_meta, rx_s;
   logic                  tick;
   logic [3:0]            sample_cnt, sample_cnt_next;
   logic [BitCntW-1:0]    bit_cnt, bit_cnt_next;
   logic [DATA_WIDTH-1:0] shift_reg, shift_next;
   logic                  samp7, samp8;
   logic                  vote, vote_point;
   logic                  frame_good, frame_bad;

   // Synchronizer flops reset high so a reset looks like an idle line.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= i_uart;
         rx_s    <= rx_meta;
      end
   end

   uart_rx_tick_gen #(
      .TicksPerSample(TicksPerSample)
   ) u_tick_gen (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .clear (state == IDLE),
      .enable(state != IDLE),
      .tick  (tick)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         samp7 <= 1'b0;
         samp8 <= 1'b0;
      end else if (tick) begin
         if (sample_cnt == SampleFirst) samp7 <= rx_s;
         if (sample_cnt == SampleMid)   samp8 <= rx_s;
      end
   end

   // Third sample is taken live, so the vote resolves on the sample-9 tick.
   assign vote_point = tick && (sample_cnt == SampleVote);
   assign vote       = majority3(samp7, samp8, rx_s);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         sample_cnt <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
      end else begin
         state      <= state_next;
         sample_cnt <= sample_cnt_next;
         bit_cnt    <= bit_cnt_next;
         shift_reg  <= shift_next;
      end
   end

   always_comb begin
      state_next      = state;
      sample_cnt_next = sample_cnt;
      bit_cnt_next    = bit_cnt;
      shift_next      = shift_reg;
      frame_good      = 1'b0;
      frame_bad       = 1'b0;
      if (tick) sample_cnt_next = sample_cnt + 4'd1;
      case (state)
         IDLE: begin
            sample_cnt_next = '0;
            if (!rx_s) state_next = START;
         end
         START: begin
            if (vote_point && vote) begin
               state_next = IDLE;
            end else if (tick && sample_cnt == SampleLast) begin
               state_next   = DATA;
               bit_cnt_next = '0;
            end
         end
         DATA: begin
            if (vote_point) shift_next = {vote, shift_reg[DATA_WIDTH-1:1]};
            if (tick && sample_cnt == SampleLast) begin
               bit_cnt_next = bit_cnt + BitCntW'(1);
               if (bit_cnt == BitLast) state_next = STOP;
            end
         end
         STOP: begin
            // Leaving mid-stop-bit lets a back-to-back start edge be caught.
            if (vote_point) begin
               if (vote) begin
                  frame_good = 1'b1;
                  state_next = IDLE;
               end else begin
                  frame_bad  = 1'b1;
                  state_next = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            if (rx_s) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_data        <= '0;
         o_valid       <= 1'b0;
         o_frame_error <= 1'b0;
         o_overrun     <= 1'b0;
      end else begin
         o_frame_error <= frame_bad;
         o_overrun     <= 1'b0;
         if (frame_good) begin
            if (!o_valid || i_ready) begin
               o_data  <= shift_reg;
               o_valid <= 1'b1;
            end else begin
               o_overrun <= 1'b1;
            end
         end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

endmodule
